// File: rtl/bit_serial_adder.sv
// bit_serial_adder: WIDTH-bit adder using one full-adder cell, one bit per clock, LSB first
// Ports: clk/rst (async active-high), in_valid/in_ready + a, b, c_in (operand handshake),
//        out_valid/out_ready + sum, c_out (result handshake), busy (high while shifting).
// Optional: define SERIAL_ADD_OVF_EN to add ovf, the registered signed two's-complement overflow flag.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CNT_W = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t           state_q;
    logic             in_ready_q, out_valid_q, busy_q, c_out_q, carry_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q, sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             s_d, carry_d, last_d;
    logic [WIDTH-1:0] sum_sr_d;
    logic [CNT_W-1:0] cnt_d;
    assign s_d      = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign carry_d  = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    assign sum_sr_d = {s_d, sum_sr_q[WIDTH-1:1]};
    assign cnt_d    = cnt_q + CNT_W'(1);
    assign last_d   = cnt_q == CNT_W'(WIDTH - 1);
`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_sr_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_sr_q     <= a;
                    b_sr_q     <= b;
                    carry_q    <= c_in;
                    cnt_q      <= '0;
                    state_q    <= RUN;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
                RUN: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    sum_sr_q <= sum_sr_d;
                    carry_q  <= carry_d;
                    cnt_q    <= cnt_d;
                    if (last_d) begin
                        // carry_q here is the carry into the MSB, carry_d the carry out of it
                        sum_q       <= sum_sr_d;
                        c_out_q     <= carry_d;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_q       <= carry_q ^ carry_d;
`endif
                        state_q     <= HOLD;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                HOLD: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder built around a single full-adder cell (a, b, c_in -> sum, c_out) with a registered carry.
- Sits directly upstream of result consumers: it takes parallel operands through a valid/ready handshake, feeds the cell one bit per clock (LSB first), and returns the parallel sum and carry-out through a valid/ready handshake.
- Trades latency for area: one full-adder cell instead of WIDTH cells.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operands a, b, c_in valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry into bit 0
- out_valid  output  1  sum, c_out valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  A + B + c_in, low WIDTH bits
- c_out  output  1  carry out of bit WIDTH-1
- busy  output  1  high in RUN state

Behaviour:
- Reset: clk and rst only; rst is asynchronous and active-high.
  - Asserting rst immediately forces state IDLE, in_ready=1, out_valid=0, busy=0, sum=0, c_out=0, counter=0, carry register=0.
  - This holds even mid-RUN or in HOLD; the pending operation is discarded.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: latch a and b into shift registers, load the carry register with c_in, clear the counter, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: compute s = a_sr[0] ^ b_sr[0] ^ carry and cout = majority(a_sr[0], b_sr[0], carry).
  - Shift a_sr and b_sr right by 1. Shift s into the MSB of the sum shift register (sum_sr shifts right). Load carry with cout. Increment the counter.
  - On the edge where counter == WIDTH-1: go to HOLD. sum_sr then holds the full result, LSB at bit 0.
- HOLD:
  - out_valid=1, in_ready=0, busy=0.
  - sum and c_out are stable and equal to the registered values.
  - On an edge with out_ready=1, go to IDLE.
  - out_ready may stay low indefinitely; the result is held unchanged.
- Latency:
  - The accept edge is E0; out_valid rises after edge E_WIDTH (WIDTH clocks).
  - Minimum issue interval is WIDTH+2 clocks: accept, WIDTH shifts, output handshake, return to IDLE.
  - in_ready is not asserted in HOLD; there is no overlap.
- Outputs:
  - sum and c_out are driven from registers at all times.
  - Outside HOLD their value is don't-care for consumers.
  - Outside HOLD they are guaranteed to hold the last result or the reset value; they never show partial sums.
  - Implement with separate output registers updated on RUN -> HOLD.
- Arithmetic: unsigned, modulo 2^WIDTH. c_out is the true carry. No truncation warnings; all internal widths are exact.
- Simultaneous events:
  - in_valid while in RUN or HOLD is ignored; operands are not sampled.
  - out_ready while not in HOLD is ignored.
  - a, b and c_in may change freely after the accept edge.

Optional Feature:
- Macro SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit). It is registered with sum and c_out on RUN -> HOLD.
  - ovf = (carry into bit WIDTH-1) XOR c_out, i.e. signed two's-complement overflow.
  - ovf resets to 0 and is valid under the same out_valid qualification.
- Not defined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8; a=8'h3C, b=8'h0F, c_in=0 -> out_valid exactly 8 clocks after the accept edge; sum=8'h4B, c_out=0.
- a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1. a=8'hFF, b=8'hFF, c_in=1 -> sum=8'hFF, c_out=1.
- Backpressure: after a=8'h10, b=8'h20, hold out_ready=0 for 6 clocks, with in_valid=1 throughout:
  - out_valid stays 1, sum=8'h30 stable, in_ready=0, no second operand accepted.
  - out_ready=1 -> IDLE next clock, in_ready=1.
- Reset mid-operation: assert rst asynchronously (between edges) during RUN at counter=3:
  - Outputs go to reset values immediately.
  - After release, a=8'h01, b=8'h01, c_in=1 -> sum=8'h03, c_out=0.
- With SERIAL_ADD_OVF_EN:
  - a=8'h7F, b=8'h01 -> sum=8'h80, c_out=0, ovf=1.
  - a=8'h80, b=8'h80 -> sum=8'h00, c_out=1, ovf=1.
  - a=8'hFF, b=8'h01 -> ovf=0.
- Randomized back-to-back: 200 ops with random out_ready -> every result matches a+b+c_in; issue interval is never below 10 clocks.
